squeeze_conv_engine: RTL
========================

SQUEEZE_CONV_ENGINE -- requirements
Module: squeeze_conv_engine

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- WIDTH, 16, pixel/weight/output width, signed fixed point
- DSP_NO, 64, parallel output channels (MAC lanes)
- CHIN, 256, input channels per output pixel
- KERNEL_DIM, 3, kernel side
- WOUT, 16, output feature-map side
- FRAC_SHIFT, 14, arithmetic right shift applied before output truncation
REQ-002 Ports (name, direction, width, meaning), one per line:
- clk, in, 1, clock
- rst, in, 1, asynchronous active-low reset
- layer_en_i, in, 1, layer enable
- ifm_valid_i, in, 1, ifm_i valid this cycle
- ifm_i, in, WIDTH, input pixel stream
- ker_addr_o, out, clog2(DEPTH), weight ROM address, DEPTH = KERNEL_DIM^2*CHIN
- ker_i, in, DSP_NO*WIDTH, weights for all lanes, lane i at [i*WIDTH +: WIDTH]
- bias_i, in, DSP_NO*2*WIDTH, per-lane bias, lane i at [i*2*WIDTH +: 2*WIDTH]
- ram_feedback_i, in, 1, downstream RAM has taken the layer
- ofm_o, out, DSP_NO*WIDTH, output pixel, all lanes
- ofm_valid_o, out, 1, one-cycle sample strobe for ofm_o
- layer_done_o, out, 1, all WOUT^2 pixels produced
- finish_o, out, 1, layer_done_o AND NOT sticky ram_feedback

Function
REQ-003 FSM states IDLE, RUN, DONE; IDLE->RUN when layer_en_i=1; RUN->DONE in the cycle ofm_valid_o issues pixel WOUT^2; DONE holds until reset.
REQ-004 Accept = RUN AND layer_en_i AND ifm_valid_i; no other cycle changes the window counter or accumulators.
REQ-005 layer_en_i=0 during RUN pauses (no accept); state and counters are kept.
REQ-006 ker_addr_o is the registered window counter (0..DEPTH-1); it advances on accept and wraps from DEPTH-1 to 0.
REQ-007 External ROM latency is 1 cycle; the engine registers ifm_i on accept so the pixel and ker_i meet in the following cycle.
REQ-008 Each lane forms a signed WIDTH x WIDTH product (2*WIDTH) and accumulates in 2*WIDTH two's complement with wrap, no saturation.
REQ-009 The first term of each window loads the accumulator (clear-and-load); back-to-back windows need no bubble cycle.
REQ-010 Window close: s = acc + bias (2*WIDTH, wrap); r = s >>> FRAC_SHIFT; r saturates to [-2^(WIDTH-1), 2^(WIDTH-1)-1]; the result is registered into ofm_o.
REQ-011 ofm_valid_o pulses exactly 3 cycles after the accept of window term DEPTH-1; ofm_o is held until the next pulse.
REQ-012 The output pixel counter increments per ofm_valid_o and never exceeds WOUT^2; layer_done_o=1 from the cycle after pulse WOUT^2.
REQ-013 ram_feedback_i sets a sticky flag; finish_o = layer_done_o AND NOT flag (flag already set -> finish_o never rises).
REQ-014 Inputs arriving in IDLE or DONE are ignored; ofm_valid_o for the final window still issues after the RUN->DONE transition if it is in flight.

Reset
REQ-015 rst=0 asynchronously forces: state IDLE, counters 0, accumulators 0, ker_addr_o 0, ofm_o 0, ofm_valid_o 0, layer_done_o 0, finish_o 0, feedback flag 0, pipeline valids 0.
REQ-016 Reset mid-window discards partial sums; after release the next accept starts window term 0.

Configuration
REQ-017 Macro SQUEEZE_RELU_EN: if defined, s<0 at window close yields ofm lane 0 (ReLU before shift/saturate); if undefined, signed output per REQ-010 only.

Verification (WIDTH=16, DSP_NO=2, CHIN=2, KERNEL_DIM=1, WOUT=2, FRAC_SHIFT=0 unless noted)
REQ-018 Pixels 3,4 continuous, weights lane0 (2,5), lane1 (-1,1), bias (10,0) -> ofm_valid_o 3 cycles after 2nd accept; lane0=36, lane1=1 (ReLU off).
REQ-019 Same with lane1 bias -10, SQUEEZE_RELU_EN defined -> lane1=0; undefined -> lane1=-9 (0xFFF7).
REQ-020 Eight continuous pixels with ifm_valid_i gaps and one layer_en_i drop -> exactly 4 ofm_valid_o, layer_done_o after the 4th, further pixels ignored.
REQ-021 Product 0x7FFF*0x7FFF summed twice, FRAC_SHIFT=14 -> lane saturates to 0x7FFF.
REQ-022 rst pulsed after 1st pixel of a window, then 2 pixels -> single correct result from the post-reset pair only.
REQ-023 ram_feedback_i pulsed after layer_done_o -> finish_o 1 then 0 next cycle, stays 0.

Source files
------------

// File: rtl/squeeze_conv_engine.sv
// Multi-lane MAC engine for squeeze/1x1-style convolution: streams one pixel per accept against
// a weight ROM, closes each window with bias, shift and saturation. Optional ReLU: SQUEEZE_RELU_EN.
module squeeze_conv_engine #(
  parameter int WIDTH      = 16,
  parameter int DSP_NO     = 64,
  parameter int CHIN       = 256,
  parameter int KERNEL_DIM = 3,
  parameter int WOUT       = 16,
  parameter int FRAC_SHIFT = 14,
  localparam int DEPTH     = KERNEL_DIM * KERNEL_DIM * CHIN,
  localparam int AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        layer_en_i,
  input  logic                        ifm_valid_i,
  input  logic [WIDTH-1:0]            ifm_i,
  output logic [AW-1:0]               ker_addr_o,
  input  logic [DSP_NO*WIDTH-1:0]     ker_i,
  input  logic [DSP_NO*2*WIDTH-1:0]   bias_i,
  input  logic                        ram_feedback_i,
  output logic [DSP_NO*WIDTH-1:0]     ofm_o,
  output logic                        ofm_valid_o,
  output logic                        layer_done_o,
  output logic                        finish_o,
  output logic [1:0]                  dbg_state_o
);
  localparam int NPIX = WOUT * WOUT;
  localparam int PCW  = $clog2(NPIX + 1);
  localparam logic signed [2*WIDTH-1:0] SAT_MAX = (2*WIDTH)'((2**(WIDTH-1)) - 1);
  localparam logic signed [2*WIDTH-1:0] SAT_MIN = -SAT_MAX - 1;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
  state_t state_q, state_d;

  logic [AW-1:0]                 addr_q, addr_d;
  logic signed [WIDTH-1:0]       ifm_q;
  logic                          v1_q, first1_q, last1_q;
  logic signed [2*WIDTH-1:0]     prod_q [DSP_NO];
  logic                          v2_q, first2_q, last2_q;
  logic signed [2*WIDTH-1:0]     acc_q [DSP_NO];
  logic                          v3_q, last3_q;
  logic [DSP_NO*WIDTH-1:0]       ofm_q, ofm_d;
  logic                          ofm_valid_q, ofm_valid_d;
  logic [PCW-1:0]                pix_q, pix_d;
  logic                          fb_q;
  logic                          accept;
  logic signed [2*WIDTH-1:0]     sum_w [DSP_NO];
  logic signed [2*WIDTH-1:0]     shr_w [DSP_NO];

  assign accept = (state_q == RUN) && layer_en_i && ifm_valid_i;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (layer_en_i) state_d = RUN;
      RUN:     if (ofm_valid_q && pix_q == PCW'(NPIX - 1)) state_d = DONE;
      default: state_d = DONE;
    endcase
  end

  // Pixel count caps at NPIX; a pulse is suppressed once the layer has all its pixels.
  always_comb begin
    addr_d = addr_q;
    if (accept) addr_d = (addr_q == AW'(DEPTH - 1)) ? '0 : addr_q + 1'b1;
    pix_d = (ofm_valid_q && pix_q != PCW'(NPIX)) ? pix_q + 1'b1 : pix_q;
    ofm_valid_d = v3_q && last3_q && (pix_d != PCW'(NPIX));
  end

  always_comb begin
    ofm_d = '0;
    for (int i = 0; i < DSP_NO; i++) begin
      sum_w[i] = acc_q[i] + $signed(bias_i[i*2*WIDTH +: 2*WIDTH]);
      shr_w[i] = sum_w[i] >>> FRAC_SHIFT;
`ifdef SQUEEZE_RELU_EN
      if (sum_w[i] < 0) shr_w[i] = '0;
`endif
      if (shr_w[i] > SAT_MAX)      ofm_d[i*WIDTH +: WIDTH] = SAT_MAX[WIDTH-1:0];
      else if (shr_w[i] < SAT_MIN) ofm_d[i*WIDTH +: WIDTH] = SAT_MIN[WIDTH-1:0];
      else                         ofm_d[i*WIDTH +: WIDTH] = shr_w[i][WIDTH-1:0];
    end
  end

  // Stage 1 registers the pixel while the ROM fetches; stage 2 multiplies; stage 3 accumulates.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      ifm_q       <= '0;
      v1_q        <= 1'b0;
      first1_q    <= 1'b0;
      last1_q     <= 1'b0;
      v2_q        <= 1'b0;
      first2_q    <= 1'b0;
      last2_q     <= 1'b0;
      v3_q        <= 1'b0;
      last3_q     <= 1'b0;
      ofm_q       <= '0;
      ofm_valid_q <= 1'b0;
      pix_q       <= '0;
      fb_q        <= 1'b0;
      for (int i = 0; i < DSP_NO; i++) begin
        prod_q[i] <= '0;
        acc_q[i]  <= '0;
      end
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      v1_q        <= accept;
      if (accept) begin
        ifm_q    <= $signed(ifm_i);
        first1_q <= (addr_q == '0);
        last1_q  <= (addr_q == AW'(DEPTH - 1));
      end
      v2_q        <= v1_q;
      first2_q    <= first1_q;
      last2_q     <= last1_q;
      v3_q        <= v2_q;
      last3_q     <= last2_q;
      for (int i = 0; i < DSP_NO; i++) begin
        if (v1_q) prod_q[i] <= ifm_q * $signed(ker_i[i*WIDTH +: WIDTH]);
        if (v2_q) acc_q[i]  <= first2_q ? prod_q[i] : acc_q[i] + prod_q[i];
      end
      if (ofm_valid_d) ofm_q <= ofm_d;
      ofm_valid_q <= ofm_valid_d;
      pix_q       <= pix_d;
      fb_q        <= fb_q | ram_feedback_i;
    end
  end

  assign ker_addr_o   = addr_q;
  assign ofm_o        = ofm_q;
  assign ofm_valid_o  = ofm_valid_q;
  assign layer_done_o = (pix_q == PCW'(NPIX));
  assign finish_o     = layer_done_o && !fb_q;
  assign dbg_state_o  = state_q;
endmodule
